// File: rtl/game_pkg.sv
// game_pkg: shared code-format defaults and the secret-code generator FSM states.
package game_pkg;
  localparam int DEF_NUM_DIGITS = 4;
  localparam int DEF_DIGIT_W = 3;
  localparam int DEF_NUM_SYMBOLS = 6;
  typedef enum logic [2:0] {ST_IDLE, ST_RESEED, ST_WARMUP, ST_SHIFT, ST_CHECK} state_t;
endpackage

// File: rtl/code_dup_check.sv
// code_dup_check: flags when sample matches any digit already written (slots below idx).
module code_dup_check
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1
) (
  input  logic [NUM_DIGITS*DIGIT_W-1:0] code,
  input  logic [IW-1:0]                 idx,
  input  logic [DIGIT_W-1:0]            sample,
  output logic                          dup
);
  // Slots at or above idx hold stale digits from an older code and are ignored.
  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++)
      dup = dup | ((IW'(i) < idx) && (code[i*DIGIT_W +: DIGIT_W] == sample));
  end
endmodule

// File: rtl/secret_code_gen.sv
// secret_code_gen: packs the serial LFSR stream into a secret code via rejection sampling.
module secret_code_gen
  import game_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int NUM_SYMBOLS = DEF_NUM_SYMBOLS,
  parameter int NO_REPEAT = 0,
  parameter int MAX_REJECT = 7,
  parameter int WARMUP = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          reseed,
  input  logic                          rng_bit,
  output logic                          rng_rst,
  output logic                          busy,
  output logic                          code_valid,
  output logic [NUM_DIGITS*DIGIT_W-1:0] code
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = DIGIT_W > 1 ? $clog2(DIGIT_W) : 1;
  localparam int RW = MAX_REJECT > 0 ? $clog2(MAX_REJECT + 1) : 1;
  localparam int WW = WARMUP > 1 ? $clog2(WARMUP) : 1;
  state_t state, state_nx;
  logic [DIGIT_W-1:0] sample, digit;
  logic [IW-1:0] idx;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] rej_cnt;
  logic [WW-1:0] wu_cnt;
  logic oor, dup, reject, force_acc, last;
  code_dup_check #(.NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W)) u_dup (
    .code(code), .idx(idx), .sample(sample), .dup(dup)
  );
  // Digit legality; a forced digit folds an out-of-range sample back into range.
  always_comb begin
    oor = {1'b0, sample} >= (DIGIT_W + 1)'(NUM_SYMBOLS);
    reject = oor || (NO_REPEAT != 0 && dup);
    force_acc = rej_cnt == RW'(MAX_REJECT);
    last = idx == IW'(NUM_DIGITS - 1);
    digit = oor ? sample - DIGIT_W'(NUM_SYMBOLS) : sample;
  end
  // State register.
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_nx;
  // Next state; the LFSR restart is a pure decode of the single-cycle RESEED state.
  always_comb begin
    state_nx = state;
    rng_rst = state == ST_RESEED;
    case (state)
      ST_IDLE:   state_nx = start ? (reseed ? ST_RESEED : ST_SHIFT) : ST_IDLE;
      ST_RESEED: state_nx = ST_WARMUP;
      ST_WARMUP: state_nx = wu_cnt == WW'(WARMUP - 1) ? ST_SHIFT : ST_WARMUP;
      ST_SHIFT:  state_nx = bit_cnt == BW'(DIGIT_W - 1) ? ST_CHECK : ST_SHIFT;
      ST_CHECK:  state_nx = (reject && !force_acc) || !last ? ST_SHIFT : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end
  // Datapath: counters, sample shifter and code storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      code_valid <= 1'b0;
      code <= '0;
      sample <= '0;
      idx <= '0;
      bit_cnt <= '0;
      rej_cnt <= '0;
      wu_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          code_valid <= 1'b0;
          busy <= 1'b1;
          idx <= '0;
          bit_cnt <= '0;
          rej_cnt <= '0;
          wu_cnt <= '0;
        end
        ST_WARMUP: wu_cnt <= wu_cnt + 1'b1;
        ST_SHIFT: begin
          sample <= {sample[DIGIT_W-2:0], rng_bit};
          bit_cnt <= bit_cnt == BW'(DIGIT_W - 1) ? '0 : bit_cnt + 1'b1;
        end
        ST_CHECK: if (reject && !force_acc) rej_cnt <= rej_cnt + 1'b1;
        else begin
          code[idx*DIGIT_W +: DIGIT_W] <= digit;
          rej_cnt <= '0;
          if (last) begin
            code_valid <= 1'b1;
            busy <= 1'b0;
          end else idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_secret_code_gen.sv
// tb_secret_code_gen: directed tests for the secret code generator.
module tb_secret_code_gen;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, reseed = 1'b0, rng_bit = 1'b0;
  logic rng_rst, busy, code_valid, rr_b, busy_b, cv_b;
  logic [11:0] code, code_b;
  int cmp = 0, bad = 0, rr_cnt, la, lb;
  logic busy0, cv0;
  logic [11:0] code0;
  logic q[$];
  always #5 clk = ~clk;
  secret_code_gen dut (
    .clk(clk), .rst(rst), .start(start), .reseed(reseed), .rng_bit(rng_bit),
    .rng_rst(rng_rst), .busy(busy), .code_valid(code_valid), .code(code)
  );
  secret_code_gen #(.NO_REPEAT(1)) dut_nr (
    .clk(clk), .rst(rst), .start(start), .reseed(reseed), .rng_bit(rng_bit),
    .rng_rst(rr_b), .busy(busy_b), .code_valid(cv_b), .code(code_b)
  );
  task automatic push(input logic [2:0] s);
    q.push_back(s[2]); q.push_back(s[1]); q.push_back(s[0]); q.push_back(1'b0);
  endtask
  task automatic run(input logic rs, input int poke, output int lat_a, output int lat_b);
    int n;
    lat_a = -1; lat_b = -1; rr_cnt = 0;
    start = 1'b1; reseed = rs; rng_bit = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; reseed = 1'b0;
    busy0 = busy; cv0 = code_valid; code0 = code;
    if (rng_rst) rr_cnt++;
    n = 0;
    while ((lat_a < 0 || lat_b < 0) && n < 300) begin
      rng_bit = 1'b0;
      if (q.size() > 0) rng_bit = q.pop_front();
      start = (n == poke); reseed = (n == poke);
      @(posedge clk); #1;
      n++;
      start = 1'b0; reseed = 1'b0;
      if (rng_rst) rr_cnt++;
      if (lat_a < 0 && code_valid) lat_a = n;
      if (lat_b < 0 && cv_b) lat_b = n;
    end
    q.delete();
  endtask
  task automatic test_reset;
    #23;
    cmp += 4;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    if (code_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", code_valid); end
    if (code !== 12'h000) begin bad++; $display("FAIL reset_code got %h want 000", code); end
    if (rng_rst !== 1'b0) begin bad++; $display("FAIL reset_rng_rst got %b want 0", rng_rst); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
  endtask
  task automatic test_basic;
    push(3'd5); push(3'd2); push(3'd3); push(3'd1);
    run(1'b0, -1, la, lb);
    cmp += 7;
    if (busy0 !== 1'b1) begin bad++; $display("FAIL basic_busy_start got %b want 1", busy0); end
    if (la !== 16) begin bad++; $display("FAIL basic_latency got %0d want 16", la); end
    if (code !== 12'h2D5) begin bad++; $display("FAIL basic_code got %h want 2d5", code); end
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_done got %b want 0", busy); end
    if (code_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got %b want 1", code_valid); end
    if (rr_cnt !== 0) begin bad++; $display("FAIL basic_rng_rst got %0d want 0", rr_cnt); end
    if (code_b !== 12'h2D5) begin bad++; $display("FAIL basic_code_nr got %h want 2d5", code_b); end
    repeat (3) @(posedge clk);
    #1 cmp += 2;
    if (code_valid !== 1'b1) begin bad++; $display("FAIL hold_valid got %b want 1", code_valid); end
    if (code !== 12'h2D5) begin bad++; $display("FAIL hold_code got %h want 2d5", code); end
  endtask
  task automatic test_reject;
    push(3'd7); push(3'd4); push(3'd2); push(3'd3); push(3'd1);
    run(1'b0, -1, la, lb);
    cmp += 5;
    if (cv0 !== 1'b0) begin bad++; $display("FAIL rej_valid_cleared got %b want 0", cv0); end
    if (code0 !== 12'h2D5) begin bad++; $display("FAIL rej_code_kept got %h want 2d5", code0); end
    if (la !== 20) begin bad++; $display("FAIL rej_latency got %0d want 20", la); end
    if (code !== 12'h2D4) begin bad++; $display("FAIL rej_code got %h want 2d4", code); end
    if (rr_cnt !== 0) begin bad++; $display("FAIL rej_rng_rst got %0d want 0", rr_cnt); end
  endtask
  task automatic test_force;
    repeat (8) push(3'd7);
    push(3'd7); push(3'd2); push(3'd3); push(3'd4);
    run(1'b0, -1, la, lb);
    cmp += 2;
    if (la !== 48) begin bad++; $display("FAIL force_latency got %0d want 48", la); end
    if (code !== 12'h8D1) begin bad++; $display("FAIL force_code got %h want 8d1", code); end
  endtask
  task automatic test_norepeat;
    push(3'd2); push(3'd2); push(3'd3); push(3'd4); push(3'd5);
    run(1'b0, -1, la, lb);
    cmp += 4;
    if (lb !== 20) begin bad++; $display("FAIL nr_latency got %0d want 20", lb); end
    if (code_b !== 12'hB1A) begin bad++; $display("FAIL nr_code got %h want b1a", code_b); end
    if (la !== 16) begin bad++; $display("FAIL rep_latency got %0d want 16", la); end
    if (code !== 12'h8D2) begin bad++; $display("FAIL rep_code got %h want 8d2", code); end
  endtask
  task automatic test_reseed;
    repeat (33) q.push_back(1'b1);
    push(3'd5); push(3'd2); push(3'd3); push(3'd1);
    run(1'b1, -1, la, lb);
    cmp += 3;
    if (rr_cnt !== 1) begin bad++; $display("FAIL reseed_pulses got %0d want 1", rr_cnt); end
    if (la !== 49) begin bad++; $display("FAIL reseed_latency got %0d want 49", la); end
    if (code !== 12'h2D5) begin bad++; $display("FAIL reseed_code got %h want 2d5", code); end
  endtask
  task automatic test_busy_start;
    push(3'd1); push(3'd3); push(3'd5); push(3'd0);
    run(1'b0, 5, la, lb);
    cmp += 3;
    if (la !== 16) begin bad++; $display("FAIL busy_start_latency got %0d want 16", la); end
    if (rr_cnt !== 0) begin bad++; $display("FAIL busy_start_rng_rst got %0d want 0", rr_cnt); end
    if (code !== 12'h159) begin bad++; $display("FAIL busy_start_code got %h want 159", code); end
  endtask
  task automatic test_reset_mid;
    start = 1'b1; rng_bit = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 cmp += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy); end
    #2 rst = 1'b0;
    #1 cmp += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    if (code_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", code_valid); end
    if (code !== 12'h000) begin bad++; $display("FAIL mid_rst_code got %h want 000", code); end
    if (rng_rst !== 1'b0) begin bad++; $display("FAIL mid_rst_rng_rst got %b want 0", rng_rst); end
    if (busy_b !== 1'b0) begin bad++; $display("FAIL mid_rst_busy_nr got %b want 0", busy_b); end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    push(3'd5); push(3'd2); push(3'd3); push(3'd1);
    run(1'b0, -1, la, lb);
    cmp += 2;
    if (la !== 16) begin bad++; $display("FAIL post_rst_latency got %0d want 16", la); end
    if (code !== 12'h2D5) begin bad++; $display("FAIL post_rst_code got %h want 2d5", code); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_reject;
    test_force;
    test_norepeat;
    test_reseed;
    test_busy_start;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end
endmodule
